// File: rtl/divider_ratio_ctrl_if.sv
// divider_ratio_ctrl_if
//   Groups the requester-side and divider-side signals of divider_ratio_ctrl.
//   master : requesters plus the divider feedback (drives req, req_div, div_clkout)
//   slave  : the controller (drives gnt, divide_out, div_update, busy, timeout_flag)
// Signals:
//   req          NREQ        level change request per requester, held until gnt
//   req_div      NREQ*DIV_W  requested ratios, slice i = [i*DIV_W +: DIV_W]
//   div_clkout   1           divider clkout fed back, synchronous to clk
//   gnt          NREQ        one-hot, one-cycle acknowledge
//   divide_out   DIV_W       ratio driven into the divider divide_in
//   div_update   1           one-cycle pulse aligned with a new divide_out
//   busy         1           controller is not idle
//   timeout_flag 1           sticky forced-progress indicator
interface divider_ratio_ctrl_if #(
  parameter int NREQ  = 4,
  parameter int DIV_W = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*DIV_W-1:0] req_div;
  logic                  div_clkout;
  logic [NREQ-1:0]       gnt;
  logic [DIV_W-1:0]      divide_out;
  logic                  div_update;
  logic                  busy;
  logic                  timeout_flag;

  modport master (
    output req, req_div, div_clkout,
    input  gnt, divide_out, div_update, busy, timeout_flag
  );

  modport slave (
    input  req, req_div, div_clkout,
    output gnt, divide_out, div_update, busy, timeout_flag
  );
endinterface

// File: rtl/divider_ratio_ctrl.sv
// divider_ratio_ctrl
//   Round-robin arbiter that sequences divide-ratio change requests into a
//   clock divider. A new ratio is only applied on a rising edge of the
//   divider's own clkout, and after each change further changes are held off
//   until SETTLE_EDGES more clkout rising edges have been seen.
// Ports:
//   clk  system clock (also clocks the divider)
//   rst  synchronous reset, active-high
//   bus  divider_ratio_ctrl_if.slave: req/req_div/div_clkout in,
//        gnt/divide_out/div_update/busy/timeout_flag out
// Optional feature:
//   Define DIVCTL_TIMEOUT_EN to add a TIMEOUT_CYC watchdog in WAIT_EDGE and
//   SETTLE that forces progress and sets a sticky timeout_flag. Without it the
//   block waits indefinitely and timeout_flag is tied low.
module divider_ratio_ctrl #(
  parameter int               NREQ         = 4,
  parameter int               DIV_W        = 8,
  parameter logic [DIV_W-1:0] DEFAULT_DIV  = DIV_W'(1),
  parameter int               SETTLE_EDGES = 2,
  parameter int               TIMEOUT_CYC  = 1024
) (
  input logic                 clk,
  input logic                 rst,
  divider_ratio_ctrl_if.slave bus
);

  localparam int         PTR_W      = $clog2(NREQ);
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE_EDGES);

  // Elaboration-time parameter sanity checks
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("divider_ratio_ctrl: NREQ must be 2..8");
  end
  if (SETTLE_EDGES < 0 || SETTLE_EDGES > 15) begin : g_bad_settle
    $error("divider_ratio_ctrl: SETTLE_EDGES must be 0..15");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("divider_ratio_ctrl: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE,
    APPLY,
    SETTLE
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [DIV_W-1:0] lat_div;
  logic [DIV_W-1:0] divide_q;
  logic [NREQ-1:0]  gnt_q;
  logic             div_update_q;
  logic             busy_q;
  logic             clkout_q;
  logic [3:0]       edge_cnt;

  logic             rise;
  logic             tmo_expire;
  logic             win_valid;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] ptr_next;
  logic [DIV_W-1:0] win_div;

  assign rise = bus.div_clkout & ~clkout_q;

  // Round-robin search: first set request at or after ptr, wrapping.
  always_comb begin
    int cand;
    logic [PTR_W-1:0] cidx;
    cand      = 0;
    cidx      = '0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cidx = PTR_W'(cand);
      if (!win_valid && bus.req[cidx]) begin
        win_valid = 1'b1;
        win_idx   = cidx;
      end
    end
  end

  // Select the winner's ratio slice and the pointer that follows it.
  always_comb begin
    win_div = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_idx == PTR_W'(k)) begin
        win_div = bus.req_div[k*DIV_W +: DIV_W];
      end
    end
    ptr_next = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
  end

`ifdef DIVCTL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_flag_q;

  assign tmo_expire = ((state == WAIT_EDGE) || (state == SETTLE)) &&
                      (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // Watchdog runs only while waiting; IDLE and APPLY are the only ways into
  // the waiting states, so clearing it there gives a fresh count on entry.
  // The flag is set only when the expiry is what actually moves the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt    <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      if ((state == WAIT_EDGE) || (state == SETTLE)) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
        tmo_cnt <= '0;
      end
      if (tmo_expire &&
          (((state == WAIT_EDGE) && !rise) ||
           ((state == SETTLE) && (edge_cnt != SETTLE_CNT)))) begin
        tmo_flag_q <= 1'b1;
      end
    end
  end

  assign bus.timeout_flag = tmo_flag_q;
`else
  assign tmo_expire       = 1'b0;
  assign bus.timeout_flag = 1'b0;
`endif

  // Main sequencer. gnt and div_update default low so each is a single-cycle
  // pulse; a request whose ratio already matches divide_out is acknowledged
  // but never reaches the divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ptr          <= '0;
      lat_div      <= DEFAULT_DIV;
      divide_q     <= DEFAULT_DIV;
      gnt_q        <= '0;
      div_update_q <= 1'b0;
      busy_q       <= 1'b0;
      clkout_q     <= 1'b0;
      edge_cnt     <= '0;
    end else begin
      clkout_q     <= bus.div_clkout;
      gnt_q        <= '0;
      div_update_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            gnt_q   <= NREQ'(1) << win_idx;
            lat_div <= win_div;
            ptr     <= ptr_next;
            if (win_div != divide_q) begin
              state  <= WAIT_EDGE;
              busy_q <= 1'b1;
            end
          end
        end
        WAIT_EDGE: begin
          if (rise || tmo_expire) begin
            state <= APPLY;
          end
        end
        APPLY: begin
          divide_q     <= lat_div;
          div_update_q <= 1'b1;
          edge_cnt     <= '0;
          state        <= SETTLE;
        end
        SETTLE: begin
          if ((edge_cnt == SETTLE_CNT) || tmo_expire) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (rise) begin
            edge_cnt <= edge_cnt + 4'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.divide_out = divide_q;
  assign bus.div_update = div_update_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_divider_ratio_ctrl.sv
// tb_divider_ratio_ctrl
//   Scoreboard bench for divider_ratio_ctrl. Stimulus computes the expected
//   grant order and ratio changes from the arbitration rules and queues them;
//   a negedge monitor pops and compares whenever gnt or div_update appear,
//   and checks edge alignment of each change against the observed clkout.
module tb_divider_ratio_ctrl;

  localparam int               NREQ         = 4;
  localparam int               DIV_W        = 8;
  localparam logic [DIV_W-1:0] DEFAULT_DIV  = 8'd1;
  localparam int               SETTLE_EDGES = 2;
  localparam int               TIMEOUT_CYC  = 16;

  logic clk;
  logic rst;

  divider_ratio_ctrl_if #(.NREQ(NREQ), .DIV_W(DIV_W)) bus ();

  divider_ratio_ctrl #(
    .NREQ        (NREQ),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV),
    .SETTLE_EDGES(SETTLE_EDGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int               idx;
    logic [DIV_W-1:0] ratio;
    bit               upd;
  } gexp_t;

  int               errors;
  int               checks;
  gexp_t            gnt_exp_q[$];
  logic [DIV_W-1:0] upd_exp_q[$];
  logic [DIV_W-1:0] model_div;
  int               model_ptr;
  logic [DIV_W-1:0] stim_div [NREQ];
  bit               mon_en;
  bit               clkout_hold;
  int               cyc;
  bit               rise_hist [0:65535];

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global watchdog so the run always ends
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Divider model: clkout toggles with random half-periods of 1..3 clk cycles
  initial begin
    int half_left;
    half_left      = 2;
    bus.div_clkout = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (clkout_hold) begin
        bus.div_clkout = 1'b0;
        half_left      = 1;
      end else begin
        half_left--;
        if (half_left <= 0) begin
          bus.div_clkout = ~bus.div_clkout;
          half_left      = $urandom_range(1, 3);
        end
      end
    end
  end

  // Monitor: rise_hist[c] is the clkout rise the DUT evaluates on the clk
  // edge following negedge c.
  initial begin
    bit               pv;
    bit               prev_busy;
    bit               settling;
    bit               ok;
    int               last_gnt;
    int               settle_start;
    int               sum;
    logic [DIV_W-1:0] prev_div;
    logic [DIV_W-1:0] ev;
    gexp_t            e;
    pv           = 1'b0;
    prev_busy    = 1'b0;
    settling     = 1'b0;
    last_gnt     = 0;
    settle_start = 0;
    prev_div     = DEFAULT_DIV;
    forever begin
      @(negedge clk);
      cyc++;
      rise_hist[cyc] = bus.div_clkout & ~pv;
      pv             = bus.div_clkout;
      if (!mon_en) begin
        settling = 1'b0;
      end else begin
        if (bus.gnt != '0) begin
          if (gnt_exp_q.size() == 0) begin
            checkOutput("gnt_pending", 64'(gnt_exp_q.size()), 64'd1);
          end else begin
            e = gnt_exp_q.pop_front();
            checkOutput("gnt_onehot", 64'(bus.gnt), 64'(1 << e.idx));
            checkOutput("gnt_when_idle", 64'(prev_busy), 64'd0);
            checkOutput("busy_after_gnt", 64'(bus.busy), 64'(e.upd));
            if (e.upd) last_gnt = cyc;
          end
        end
        if (bus.div_update) begin
          if (upd_exp_q.size() == 0) begin
            checkOutput("update_pending", 64'(upd_exp_q.size()), 64'd1);
          end else begin
            ev = upd_exp_q.pop_front();
            checkOutput("divide_out", 64'(bus.divide_out), 64'(ev));
          end
          ok = rise_hist[cyc-2];
          for (int c = last_gnt; c <= cyc - 3; c++) begin
            if (rise_hist[c]) ok = 1'b0;
          end
          checkOutput("apply_on_first_rise", 64'(ok), 64'd1);
          settling     = 1'b1;
          settle_start = cyc;
        end
        if (bus.divide_out !== prev_div) begin
          checkOutput("change_only_with_update", 64'(bus.div_update), 64'd1);
        end
        if (settling && !bus.busy) begin
          sum = 0;
          for (int c = settle_start; c <= cyc - 2; c++) begin
            sum += int'(rise_hist[c]);
          end
          ok = (sum == SETTLE_EDGES) && (SETTLE_EDGES == 0 || rise_hist[cyc-2]);
          checkOutput("settle_edges", 64'(ok), 64'd1);
          settling = 1'b0;
        end
      end
      prev_div  = bus.divide_out;
      prev_busy = bus.busy;
    end
  end

  task automatic waitIdle();
    int budget;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while ((bus.busy || bus.gnt != '0 || bus.req != '0) && budget < 300);
    if (budget >= 300) checkOutput("idle_wait", 64'(bus.busy), 64'd0);
  endtask

  // Issue a set of simultaneous requests; the expected grant order and ratio
  // changes come from round-robin rules applied to the held request set.
  task automatic applyStimulus(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] pend;
    int              w;
    int              budget;
    gexp_t           e;
    waitIdle();
    pend = mask;
    while (pend != '0) begin
      w = model_ptr;
      while (!pend[w]) w = (w + 1) % NREQ;
      e.idx   = w;
      e.ratio = stim_div[w];
      e.upd   = (stim_div[w] != model_div);
      gnt_exp_q.push_back(e);
      if (e.upd) begin
        model_div = stim_div[w];
        upd_exp_q.push_back(stim_div[w]);
      end
      model_ptr = (w + 1) % NREQ;
      pend[w]   = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) bus.req_div[i*DIV_W +: DIV_W] = stim_div[i];
    bus.req = mask;
    budget = 0;
    while (bus.req != '0 && budget < 500) begin
      @(negedge clk);
      bus.req = bus.req & ~bus.gnt;
      budget++;
    end
    checkOutput("req_drained", 64'(bus.req), 64'd0);
    bus.req = '0;
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    bus.req = '0;
    repeat (3) @(posedge clk);
    #1;
    rst       = 1'b0;
    model_div = DEFAULT_DIV;
    model_ptr = 0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NREQ-1:0] acc_gnt;
    logic            acc_busy;
    logic            acc_upd;
    int              n;
    errors      = 0;
    checks      = 0;
    cyc         = 0;
    mon_en      = 1'b0;
    clkout_hold = 1'b0;
    rst         = 1'b1;
    bus.req     = '0;
    bus.req_div = '0;
    model_div   = DEFAULT_DIV;
    model_ptr   = 0;
    doReset();

    // Reset state and quiet idle
    acc_gnt  = '0;
    acc_busy = 1'b0;
    acc_upd  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc_gnt  |= bus.gnt;
      acc_busy |= bus.busy;
      acc_upd  |= bus.div_update;
    end
    checkOutput("reset_divide_out", 64'(bus.divide_out), 64'(DEFAULT_DIV));
    checkOutput("idle_gnt_quiet", 64'(acc_gnt), 64'd0);
    checkOutput("idle_busy_quiet", 64'(acc_busy), 64'd0);
    checkOutput("idle_update_quiet", 64'(acc_upd), 64'd0);
    checkOutput("reset_timeout_flag", 64'(bus.timeout_flag), 64'd0);

    mon_en = 1'b1;
    // Held multi-request from ptr 0: order 0,1,3
    stim_div[0] = 8'h11; stim_div[1] = 8'h22; stim_div[2] = 8'h33; stim_div[3] = 8'h44;
    applyStimulus(4'b1011);
    // Single requester 2 with ratio 5
    stim_div[2] = 8'd5;
    applyStimulus(4'b0100);
    // Equal-ratio request is acknowledged without an update
    stim_div[0] = 8'd3;
    applyStimulus(4'b0001);
    stim_div[1] = 8'd3;
    applyStimulus(4'b0010);
    // Ratio 0 then 7
    stim_div[3] = 8'd0;
    applyStimulus(4'b1000);
    stim_div[3] = 8'd7;
    applyStimulus(4'b1000);
    waitIdle();
    mon_en = 1'b0;

    // Reset asserted mid-SETTLE with a new request pending
    @(posedge clk);
    #1;
    bus.req_div[0 +: DIV_W] = model_div ^ 8'h5A;
    bus.req = 4'b0001;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt == '0 && n < 50);
    bus.req = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.div_update && n < 100);
    checkOutput("pre_reset_divide_out", 64'(bus.divide_out), 64'(model_div ^ 8'h5A));
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_div[3*DIV_W +: DIV_W] = 8'hEE;
    bus.req = 4'b1000;
    @(negedge clk);
    checkOutput("busy_in_settle", 64'(bus.busy), 64'd1);
    @(negedge clk);
    checkOutput("rst_divide_out", 64'(bus.divide_out), 64'(DEFAULT_DIV));
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_gnt", 64'(bus.gnt), 64'd0);
    checkOutput("rst_div_update", 64'(bus.div_update), 64'd0);
    checkOutput("rst_timeout_flag", 64'(bus.timeout_flag), 64'd0);
    @(negedge clk);
    checkOutput("rst_gnt_held", 64'(bus.gnt), 64'd0);
    bus.req = '0;
    doReset();

    // Randomized rounds
    mon_en = 1'b1;
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 3) == 0) stim_div[i] = model_div;
        else stim_div[i] = DIV_W'($urandom);
      end
      applyStimulus(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
    end
    waitIdle();
    repeat (2) @(negedge clk);
    checkOutput("queues_empty", 64'(gnt_exp_q.size() + upd_exp_q.size()), 64'd0);
    checkOutput("no_timeout_random", 64'(bus.timeout_flag), 64'd0);
    mon_en = 1'b0;

    // clkout stuck low: forced progress only with the watchdog present
    doReset();
    clkout_hold = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.req_div[0 +: DIV_W] = 8'd9;
    bus.req = 4'b0001;
    n = 0;
    do begin @(negedge clk); n++; end while (bus.gnt == '0 && n < 50);
    checkOutput("stuck_gnt", 64'(bus.gnt), 64'd1);
    bus.req = '0;
`ifdef DIVCTL_TIMEOUT_EN
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.div_update && n < 100);
    checkOutput("timeout_apply_latency", 64'(n), 64'(TIMEOUT_CYC + 1));
    checkOutput("timeout_divide_out", 64'(bus.divide_out), 64'd9);
    checkOutput("timeout_flag_set", 64'(bus.timeout_flag), 64'd1);
    n = 0;
    do begin @(negedge clk); n++; end while (bus.busy && n < 100);
    checkOutput("timeout_settle_exit", 64'(bus.busy), 64'd0);
    repeat (5) @(negedge clk);
    checkOutput("timeout_flag_sticky", 64'(bus.timeout_flag), 64'd1);
`else
    acc_upd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      acc_upd |= bus.div_update;
    end
    checkOutput("stuck_busy", 64'(bus.busy), 64'd1);
    checkOutput("stuck_divide_out", 64'(bus.divide_out), 64'(DEFAULT_DIV));
    checkOutput("stuck_no_update", 64'(acc_upd), 64'd0);
    checkOutput("stuck_timeout_flag", 64'(bus.timeout_flag), 64'd0);
`endif
    clkout_hold = 1'b0;
    doReset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
